// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants, converter state encoding and width helper
package bcd_pkg;

    localparam int BCD_DIGIT_W        = 4;
    localparam int BCD_ADJ_THRESH     = 8;
    localparam int BCD_ENC_ADJ_THRESH = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Smallest binary width able to hold 10^d - 1.
    function automatic int bin_w_for_digits(input int d);
        longint m = 1;
        int     w = 0;
        for (int i = 0; i < d; i++) m *= 10;
        while ((longint'(1) << w) < m) w++;
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: per-digit subtract-3 correction for reverse double dabble
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) ? i_digit - BCD_DIGIT_W'(3) : i_digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: one-bit-per-clock packed BCD to binary converter with valid/ready
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*DIGITS-1:0]       in_bcd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BIN_W-1:0]          out_bin,
    output logic                      out_err
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    state_t            r_state;
    state_t            w_state_nx;
    logic [SR_W-1:0]   r_sr;
    logic [SR_W-1:0]   w_shr;
    logic [SR_W-1:0]   w_sr_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIN_W-1:0]  r_bin;
    logic              r_err;
    logic [DIGITS-1:0] w_dig_bad;
    logic              w_last;

    if (BIN_W < bin_w_for_digits(DIGITS)) begin : g_bad_bin_w
        $error("BIN_W too narrow for DIGITS");
    end

    assign w_shr = r_sr >> 1;
    assign w_sr_nx[BIN_W-1:0] = w_shr[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit_adj u_adj (
            .i_digit (w_shr[BIN_W+BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .o_digit (w_sr_nx[BIN_W+BCD_DIGIT_W*g +: BCD_DIGIT_W])
        );
        assign w_dig_bad[g] = in_bcd[BCD_DIGIT_W*g +: BCD_DIGIT_W] > BCD_DIGIT_W'(9);
    end

    assign w_last    = r_cnt == CNT_W'(BIN_W - 1);
    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign out_bin   = r_bin;
    assign out_err   = r_err;

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_state_nx;
    end

    // Next state: invalid digits skip straight to DONE with the error flag.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nx = |w_dig_bad ? DONE : SHIFT;
            SHIFT:   if (w_last) w_state_nx = DONE;
            DONE:    if (out_ready) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Datapath: load on accept, shift-and-adjust while in SHIFT, capture result on the final step.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
            r_bin <= '0;
            r_err <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            if (|w_dig_bad) begin
                r_err <= 1'b1;
                r_bin <= '0;
            end else begin
                r_sr  <= {in_bcd, {BIN_W{1'b0}}};
                r_cnt <= '0;
            end
        end else if (r_state == SHIFT) begin
            r_sr  <= w_sr_nx;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                r_bin <= w_sr_nx[BIN_W-1:0];
                r_err <= 1'b0;
            end
        end
    end

    // Every valid input must have drained its BCD part completely by the final step.
    a_bcd_drained: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        (r_state == SHIFT && w_last) |-> (w_sr_nx[SR_W-1:BIN_W] == '0));

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed and full-sweep checks of the BCD to binary converter
module tb_bcd_to_bin_seq;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [11:0] in_bcd = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_err;
    logic [9:0]  out_bin;

    int n_chk = 0;
    int n_pass = 0;

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start(input logic [11:0] b);
        in_bcd   = b;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    // Cycles from the accept edge (counted as 1) until out_valid is seen, plus in_ready-low cycles.
    task automatic wait_valid(output int lat, output int low);
        lat = 1;
        low = in_ready ? 0 : 1;
        while (!out_valid && lat < 40) begin
            cyc();
            lat++;
            if (!in_ready) low++;
        end
    endtask

    task automatic conv(input string tag, input logic [11:0] b, input int exp_bin, input bit exp_err, input int exp_lat);
        int lat, low;
        out_ready = 1'b1;
        chk({tag, ".in_ready"}, in_ready, 1);
        start(b);
        wait_valid(lat, low);
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".busy_cycles"}, low, exp_lat);
        chk({tag, ".out_bin"}, out_bin, exp_bin);
        chk({tag, ".out_err"}, out_err, exp_err);
        cyc();
        chk({tag, ".released"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        int lat, low;
        bit ok;
        cyc();
        cyc();
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_bin", out_bin, 0);
        chk("rst.out_err", out_err, 0);
        sys_rst_n = 1'b1;
        cyc();

        conv("c999", 12'h999, 999, 0, 11);
        conv("c255", 12'h255, 255, 0, 11);
        conv("c000", 12'h000, 0, 0, 11);
        conv("c010", 12'h010, 10, 0, 11);
        conv("c1A3", 12'h1A3, 0, 1, 1);
        conv("c042", 12'h042, 42, 0, 11);
        conv("cF00", 12'hF00, 0, 1, 1);
        conv("c901", 12'h901, 901, 0, 11);

        out_ready = 1'b0;
        start(12'h360);
        wait_valid(lat, low);
        chk("bp.latency", lat, 11);
        ok = 1'b1;
        in_bcd   = 12'h111;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ok &= out_valid && out_bin == 10'd360 && !out_err && !in_ready;
            cyc();
        end
        chk("bp.hold", ok, 1);
        out_ready = 1'b1;
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp.idle", {out_valid, in_ready}, 2'b01);
        chk("bp.bin_held", out_bin, 360);
        cyc();
        chk("bp.no_accept", {out_valid, in_ready}, 2'b01);

        start(12'h777);
        repeat (4) cyc();
        #2 sys_rst_n = 1'b0;
        #1;
        chk("ar.in_ready", in_ready, 1);
        chk("ar.out_valid", out_valid, 0);
        chk("ar.out_bin", out_bin, 0);
        chk("ar.out_err", out_err, 0);
        cyc();
        sys_rst_n = 1'b1;
        cyc();
        conv("c123", 12'h123, 123, 0, 11);

        for (int i = 0; i < 1000; i++) begin
            logic [11:0] b;
            bit hs;
            int guard;
            b = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            out_ready = 1'b0;
            start(b);
            wait_valid(lat, low);
            chk($sformatf("sweep%0d", i), {out_valid, out_err, out_bin}, {2'b10, 10'(i)});
            hs = 1'b0;
            guard = 0;
            while (!hs && guard < 50) begin
                out_ready = 1'($urandom_range(0, 1));
                hs = out_ready;
                cyc();
                guard++;
            end
            if (!hs) chk($sformatf("sweep%0d.handshake", i), hs, 1);
        end
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential packed-BCD to binary converter using reverse double dabble (shift right, then subtract 3 from any digit ≥ 8), one bit per clock. It is the inverse of the team's combinational 8421 binary-to-BCD encoder. The traffic-light controller uses it to turn operator-entered BCD phase durations (keypad/DIP digits) into binary counter loads. Valid/ready handshakes are used on both input and output.

Parameters:
DIGITS, 3, number of packed BCD digits on the input (4 bits each).
BIN_W, 10, output binary width; must satisfy 2^BIN_W > 10^DIGITS − 1 (3→10, 2→7, 4→14).

Ports:
sys_clk  input  1  system clock, all logic rising-edge.
sys_rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_bcd is valid.
in_ready  output  1  converter can accept; high only in IDLE.
in_bcd  input  4*DIGITS  packed BCD, digit 0 in [3:0].
out_valid  output  1  result available; held until out_ready.
out_ready  input  1  consumer accepts result.
out_bin  output  BIN_W  binary result; 0 when out_err=1.
out_err  output  1  at least one input digit was > 9.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, in_ready=1, out_valid=0, out_bin=0, out_err=0, shift register=0, counter=0.
- Working register R is 4*DIGITS+BIN_W bits: {bcd_part, bin_part}. Iteration counter cnt holds 0..BIN_W−1.
- IDLE: in_ready=1. When in_valid&&in_ready (accept edge):
  - If every digit ≤ 9: load R={in_bcd, BIN_W'b0}, cnt=0, go to SHIFT.
  - Otherwise: out_err=1, out_bin=0, go to DONE. Result appears 1 cycle after accept.
- SHIFT: each cycle R = adj(R >> 1). adj subtracts 3 from each 4-bit BCD field whose value is ≥ 8; fields are adjusted independently and in parallel. cnt increments each cycle. On the cycle where cnt==BIN_W−1, out_bin is loaded with the post-step bin_part, out_err=0, and the FSM goes to DONE.
- Latency: exactly BIN_W SHIFT cycles. out_valid rises BIN_W+1 edges after the accept edge (11 for the defaults).
- DONE: out_valid=1. out_bin and out_err are stable until the handshake. When out_valid&&out_ready, go to IDLE with out_valid=0. out_bin and out_err hold their last value after the handshake.
- in_ready=0 in SHIFT and DONE. Input is not accepted in the same cycle as the output handshake; the earliest next accept is the cycle after returning to IDLE.
- Throughput: one conversion per BIN_W+2 cycles when out_ready is held high.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Reset asserted mid-conversion aborts the conversion; no partial result is ever presented.
- Boundaries:
  - all-zero input gives out_bin=0 after the full BIN_W cycles (no early exit);
  - maximum input (all 9s) gives 10^DIGITS−1 with no overflow, per the BIN_W constraint;
  - the bcd_part is all zeros at completion for any valid input, and this is asserted in simulation.
- Pure synchronous datapath. No combinational path from in_* to out_*. in_ready and out_valid are decoded directly from state registers.

Decomposition:
- Shared package bcd_pkg:
  - constants BCD_DIGIT_W=4 and BCD_ADJ_THRESH=8 (converter) / 5 (encoder);
  - state encoding IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - function bin_w_for_digits(d) for parameter checks.
- One sub-module: bcd_digit_adj. It is combinational, 4-bit in/out, and subtracts 3 when the digit is ≥ 8. It is instantiated DIGITS times by generate. It mirrors the encoder's per-digit add-3 cell.
- Elaboration-time check that BIN_W satisfies the range constraint.

Test Plan:
- Reset then in_bcd=12'h999, in_valid 1 cycle, out_ready=1 → out_valid on accept+11, out_bin=999 (10'h3E7), out_err=0, in_ready low for 11 cycles.
- in_bcd=12'h255 → out_bin=255. in_bcd=12'h000 → out_bin=0 at the same latency. in_bcd=12'h010 → out_bin=10.
- in_bcd=12'h1A3 → out_valid on accept+1, out_err=1, out_bin=0. A following 12'h042 gives out_err=0, out_bin=42.
- Backpressure: out_ready=0 for 20 cycles after 12'h360 → out_valid and out_bin=360 held stable, in_ready=0, and a new in_valid is not accepted. out_ready pulse → IDLE next cycle.
- Reset pulsed at cycle 5 of SHIFT for 12'h777 → all outputs return to reset values immediately. A new 12'h123 afterwards gives 123 with normal latency.
- Randomised back-to-back sweep of all 1000 valid codes with random out_ready → every result equals the decimal value; the bcd_part-zero assertion never fires.
